handshake_const_match: RTL and testbench

Elastic dataflow consumer that takes data tokens on the `ins` channel, compares each against a compile-time constant, and emits a 1-bit condition token (`1` = match) on the `outs` channel. It is the receiving counterpart of the constant-source components: it checks or branches on tokens those sources produce. A 2-entry internal buffer decouples the channels, so `ins_ready` never depends combinationally on `outs_ready`. An optional saturating match counter supports debug and verification.

---
 rtl/handshake_const_match.sv | 122 ++++++++++++
 tb/tb_handshake_const_match.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/handshake_const_match.sv
// handshake_const_match: elastic consumer that compares each input token against a
// compile-time constant and emits a 1-bit match token through a 2-entry buffer.
// Optional saturating match counter enabled by defining HANDSHAKE_CONST_MATCH_CNT_EN;
// without it match_count is tied to 0 and the port list is unchanged.
module handshake_const_match #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter logic [31:0] CONST_VALUE = 32'd4,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  ins,
    input  logic                   ins_valid,
    output logic                   ins_ready,
    output logic                   outs,
    output logic                   outs_valid,
    input  logic                   outs_ready,
    output logic [COUNT_WIDTH-1:0] match_count
);

    // Only the low DATA_WIDTH bits of the constant take part in the comparison.
    localparam logic [DATA_WIDTH-1:0] MatchValue = DATA_WIDTH'(CONST_VALUE);

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } state_e;

    state_e state_q, state_d;
    logic   head_q, head_d;  // oldest buffered result, drives outs
    logic   tail_q, tail_d;  // second result, only meaningful in StFull
    logic   match;
    logic   push;
    logic   pop;

    assign match = (ins == MatchValue);

    // Ready depends on registers (and reset) only, so no path from outs_ready.
    assign ins_ready  = (state_q != StFull) && !rst;
    assign outs_valid = (state_q != StEmpty);
    // head_q keeps a stale value after the last pop, so gate it when empty.
    assign outs       = (state_q != StEmpty) ? head_q : 1'b0;

    assign push = ins_valid && ins_ready;
    assign pop  = outs_valid && outs_ready;

    // Next occupancy state and buffer contents.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    head_d  = match;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (push && pop) begin
                    // Head leaves, the new result takes its place.
                    head_d = match;
                end else if (push) begin
                    tail_d  = match;
                    state_d = StFull;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // ins_ready is low here, so only a pop can happen.
                if (pop) begin
                    head_d  = tail_q;
                    state_d = StOne;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
    end

    // Occupancy state and buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

`ifdef HANDSHAKE_CONST_MATCH_CNT_EN
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    // Count accepted matching tokens, holding at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (push && match && (count_q != {COUNT_WIDTH{1'b1}})) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    // Match counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign match_count = count_q;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_handshake_const_match.sv
// Testbench for handshake_const_match: directed and random stimulus checked against a
// queue-based reference model. A second instance with a 4-bit counter shares the inputs.
module tb_handshake_const_match;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ins = '0;
    logic        ins_valid = 1'b0;
    logic        outs_ready = 1'b0;

    logic        ins_ready, outs, outs_valid;
    logic [15:0] match_count;
    logic        ins_ready_s, outs_s, outs_valid_s;
    logic [3:0]  match_count_s;

    bit          q[$];
    int unsigned n_match = 0;
    int          checks = 0;
    int          errors = 0;

    handshake_const_match #(
        .DATA_WIDTH (32),
        .CONST_VALUE(32'd4),
        .COUNT_WIDTH(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready),
        .match_count(match_count)
    );

    handshake_const_match #(
        .DATA_WIDTH (32),
        .CONST_VALUE(32'd4),
        .COUNT_WIDTH(4)
    ) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready_s),
        .outs       (outs_s),
        .outs_valid (outs_valid_s),
        .outs_ready (outs_ready),
        .match_count(match_count_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_count(input int unsigned maxv);
`ifdef HANDSHAKE_CONST_MATCH_CNT_EN
        return (n_match > maxv) ? maxv : n_match;
`else
        return (maxv == 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic check_outputs();
        logic exp_rdy;
        logic exp_vld;
        logic exp_out;
        exp_rdy = !rst && (q.size() < 2);
        exp_vld = (q.size() > 0);
        exp_out = (q.size() > 0) ? q[0] : 1'b0;
        check("ins_ready", ins_ready, exp_rdy);
        check("outs_valid", outs_valid, exp_vld);
        check("outs", outs, exp_out);
        check("match_count", match_count, exp_count(65535));
        check("sat_ins_ready", ins_ready_s, exp_rdy);
        check("sat_outs_valid", outs_valid_s, exp_vld);
        check("sat_outs", outs_s, exp_out);
        check("sat_match_count", match_count_s, exp_count(15));
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model.
    task automatic step(input logic v, input logic [31:0] d, input logic r);
        bit do_push;
        bit do_pop;
        @(negedge clk);
        ins_valid  = v;
        ins        = d;
        outs_ready = r;
        #1;
        check_outputs();
        do_push = !rst && v && (q.size() < 2);
        do_pop  = !rst && r && (q.size() > 0);
        @(posedge clk);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            q.push_back(d == 32'd4);
            if (d == 32'd4) n_match++;
        end
    endtask

    // Assert reset between edges, check its immediate effect, release after one edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        q.delete();
        n_match = 0;
        check_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        // Reset held for three cycles.
        repeat (3) step(1'b1, 32'd4, 1'b1);
        #1 rst = 1'b0;

        // Single matching token.
        step(1'b1, 32'd4, 1'b0);
        step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b0);
`ifdef HANDSHAKE_CONST_MATCH_CNT_EN
        check("single_count", match_count, 32'd1);
`else
        check("single_count", match_count, 32'd0);
`endif

        // Backpressure: 4 and 7 absorbed, 9 waits until after the first pop.
        step(1'b1, 32'd4, 1'b0);
        step(1'b1, 32'd7, 1'b0);
        step(1'b1, 32'd9, 1'b0);
        check("bp_full_ready", ins_ready, 1'b0);
        step(1'b1, 32'd9, 1'b1);
        step(1'b1, 32'd9, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b0);

        // Streaming 100 alternating tokens.
        do_reset();
        for (int i = 0; i < 100; i++) step(1'b1, (i % 2 == 0) ? 32'd4 : 32'd5, 1'b1);
        step(1'b0, 32'd0, 1'b1);
`ifdef HANDSHAKE_CONST_MATCH_CNT_EN
        check("stream_count", match_count, 32'd50);
        check("stream_sat_count", match_count_s, 32'd15);
`else
        check("stream_count", match_count, 32'd0);
`endif

        // Saturation of the 4-bit instance.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 32'd4, 1'b1);
        step(1'b0, 32'd0, 1'b0);

        // Reset mid-operation while full.
        do_reset();
        step(1'b1, 32'd4, 1'b0);
        step(1'b1, 32'd4, 1'b0);
        do_reset();
        step(1'b1, 32'd5, 1'b0);
        step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 1) == 0) ? 32'd4 : $urandom;
            step(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0));
        end
        repeat (3) step(1'b0, 32'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
